sm_step_gen_mc: RTL and testbench
=================================

Name: sm_step_gen_mc

Overview:
Multi-channel stepper-motor step/direction pulse generator, the parametrised successor to the single-channel step pulser.
Each channel accepts a move command: period, step count and direction. It emits exactly that many fixed-width step pulses at the programmed period, honouring a direction setup time, then signals completion.
It sits between the motion-control/ADC trigger logic and the motor driver pins.
Adds over the single-channel pulser: channel count, finite step count, done/busy handshake, pause, abort and on-the-fly period update.

Parameters:
NCH, 2, number of independent channels
PW, 17, width of the period field (clk cycles between step rising edges)
CNT_W, 24, width of the step-count field
PULSE_HI, 4, step high time in clk cycles (>=1)
DIR_SETUP, 8, cycles from dir change to first step rising edge (>=1)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
load  in  NCH  per-channel command strobe, 1 cycle
period  in  NCH*PW  per-channel period; channel i is bits [i*PW +: PW]
steps  in  NCH*CNT_W  per-channel step count; channel i is bits [i*CNT_W +: CNT_W]
dir_in  in  NCH  per-channel requested direction
enable  in  NCH  per-channel run enable; 0 = pause
abort  in  NCH  per-channel abort strobe
step  out  NCH  step pulses to driver
dir  out  NCH  direction to driver
busy  out  NCH  channel executing a move
done  out  NCH  1-cycle pulse when a move completes normally

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. On reset all outputs are 0, all FSMs go to IDLE, and latched period, count and dir clear to 0.
- Channels are fully independent; the per-channel FSM is IDLE, SETUP, HIGH, LOW.
- Period clamp: effective period Pe = max(period, PULSE_HI+1), evaluated at latch time.
- IDLE:
  - load=1 with steps!=0 latches Pe, steps and dir_in. Next cycle: busy=1, dir=latched dir, state SETUP.
  - load=1 with steps==0: no latch; done=1 the next cycle; busy stays 0.
- SETUP: runs DIR_SETUP cycles, then HIGH. With load at cycle t, the first step rising edge is at t+1+DIR_SETUP.
- HIGH: step=1 for PULSE_HI cycles. The remaining count decrements on the last HIGH cycle. Then LOW.
- LOW: step=0 for Pe-PULSE_HI cycles.
  - Remaining !=0: go to HIGH, so rising edges are exactly Pe cycles apart.
  - Remaining ==0: go to IDLE with busy=0 and done=1 in the same cycle. That is Pe cycles after the last rising edge.
- Pause: enable=0 freezes the phase counter and state; step holds its current level. Resume continues from the frozen point. enable is ignored in IDLE (a load is still accepted).
- Abort:
  - abort=1 in any non-IDLE state: next cycle IDLE, step=0, busy=0, done stays 0.
  - dir holds its last value.
  - Abort wins over a simultaneous load. Abort in IDLE has no effect.
- Load while busy: only the period is taken (clamped). It takes effect at the next entry to HIGH; the LOW phase in progress keeps the old length. steps and dir_in are ignored.
- Load in the same cycle busy falls: the channel is already IDLE in that cycle, so the load is accepted as a new command.
- Counters: the phase counter is PW bits wide and never wraps, because Pe is at most 2^PW-1. The remaining counter is CNT_W bits and never underflows, because the zero check happens before decrement.
- All outputs are registered.

Decomposition:
- Package sm_step_pkg holds:
  - the FSM state enum: IDLE, SETUP, HIGH, LOW;
  - localparam widths for the state and phase counters;
  - a clamp function for Pe.
- One sub-module, sm_step_chan, holds the single-channel FSM, counters and registered step/dir/busy/done.
- The top level generate-instantiates NCH sm_step_chan instances and slices the packed buses.

Test Plan:
All scenarios use PULSE_HI=4, DIR_SETUP=8.
1. ch0 load at cycle 0, period=10, steps=3, dir_in=1 -> dir=1 and busy=1 from cycle 1; step high on cycles 9-12, 19-22 and 29-32; done=1 and busy=0 at cycle 39.
2. Load with period=2, steps=2 -> clamped to Pe=5; step high on cycles 9-12 and 14-17; done at cycle 19. Load with steps=0 -> done at cycle 1; busy never rises.
3. period=10, steps=3; enable=0 for cycles 15-19 -> step high 9-12, 24-27, 34-37; done at cycle 44.
4. period=10, steps=100; abort at cycle 20 -> cycle 21 step=0, busy=0, no done pulse. Abort and load together in the same cycle -> channel stays IDLE.
5. period=10, steps=4; reload period=20 at cycle 15 -> rising edges at cycles 9, 19, 39, 59; done at cycle 79.
6. ch0 and ch1 loaded together with different periods/counts, plus rst asserted mid-move on ch1 -> ch0 pulse train matches the single-channel model and is unaffected by ch1 activity; after rst all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/sm_step_pkg.sv
// Shared types and helpers for the multi-channel step/direction generator.
// Holds the per-channel FSM encoding, the counter widths and the period clamp.
package sm_step_pkg;

  localparam int STATE_W = 2;
  localparam int PHASE_W = 17;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } step_state_t;

  // A period shorter than the high time plus one low cycle cannot be honoured.
  function automatic int unsigned clamp_period(input int unsigned p, input int unsigned pulse_hi);
    return (p < pulse_hi + 1) ? pulse_hi + 1 : p;
  endfunction

endpackage

// File: rtl/sm_step_chan.sv
// Single step/direction channel: direction setup, PULSE_HI-wide step pulses at
// the programmed period, pause, abort and on-the-fly period update.
module sm_step_chan
  import sm_step_pkg::*;
#(
  parameter int PW        = PHASE_W,
  parameter int CNT_W     = 24,
  parameter int PULSE_HI  = 4,
  parameter int DIR_SETUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PW-1:0]    period,
  input  logic [CNT_W-1:0] steps,
  input  logic             dir_in,
  input  logic             enable,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done
);

  localparam logic [PW-1:0] SETUP_LAST = PW'(DIR_SETUP - 1);
  localparam logic [PW-1:0] HIGH_LAST  = PW'(PULSE_HI - 1);
  localparam logic [PW-1:0] LOW_OFFSET = PW'(PULSE_HI + 1);

  step_state_t      state, state_n;
  logic [PW-1:0]    phase, pe_cur, pe_pend, pe_new, pe_take;
  logic [CNT_W-1:0] remain;
  logic             idle, cmd_ok, accept, zero_cmd, update, run, phase_end;
  logic             step_d, busy_d, done_d, dir_d;

  assign pe_new   = PW'(clamp_period(32'(period), PULSE_HI));
  assign idle     = (state == IDLE);
  assign cmd_ok   = load & ~abort;
  assign accept   = cmd_ok & idle & (steps != '0);
  assign zero_cmd = cmd_ok & idle & (steps == '0);
  assign update   = cmd_ok & ~idle;
  assign run      = ~idle & enable & ~abort;
  // A period reload in the very cycle HIGH is entered already applies to that pulse.
  assign pe_take  = update ? pe_new : pe_pend;

  always_comb begin
    phase_end = 1'b0;
    case (state)
      SETUP:   phase_end = (phase == SETUP_LAST);
      HIGH:    phase_end = (phase == HIGH_LAST);
      LOW:     phase_end = (phase == pe_cur - LOW_OFFSET);
      default: phase_end = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    if (idle) begin
      if (accept) state_n = SETUP;
    end else if (abort) begin
      state_n = IDLE;
    end else if (enable && phase_end) begin
      case (state)
        SETUP:   state_n = HIGH;
        HIGH:    state_n = LOW;
        LOW:     state_n = (remain == '0) ? IDLE : HIGH;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    step_d = (state_n == HIGH);
    busy_d = (state_n != IDLE);
    done_d = zero_cmd | ((state == LOW) & (state_n == IDLE) & ~abort);
    dir_d  = accept ? dir_in : dir;
  end

  // Remaining count is only decremented after the last HIGH cycle, so it never underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      remain  <= '0;
      pe_cur  <= '0;
      pe_pend <= '0;
      step    <= 1'b0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_d;
      dir   <= dir_d;
      busy  <= busy_d;
      done  <= done_d;
      phase <= (state_n != state) ? '0 : (run ? phase + PW'(1) : phase);
      if (accept)
        remain <= steps;
      else if (run && state == HIGH && phase_end)
        remain <= remain - CNT_W'(1);
      if (accept || update)
        pe_pend <= pe_new;
      if (state_n == HIGH && state != HIGH)
        pe_cur <= pe_take;
    end
  end

endmodule

// File: rtl/sm_step_gen_mc.sv
// Multi-channel step/direction pulse generator: NCH independent channels
// sharing clock and reset, with per-channel fields packed into flat buses.
module sm_step_gen_mc
  import sm_step_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int PW        = PHASE_W,
  parameter int CNT_W     = 24,
  parameter int PULSE_HI  = 4,
  parameter int DIR_SETUP = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*PW-1:0]    period,
  input  logic [NCH*CNT_W-1:0] steps,
  input  logic [NCH-1:0]       dir_in,
  input  logic [NCH-1:0]       enable,
  input  logic [NCH-1:0]       abort,
  output logic [NCH-1:0]       step,
  output logic [NCH-1:0]       dir,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    sm_step_chan #(
      .PW        (PW),
      .CNT_W     (CNT_W),
      .PULSE_HI  (PULSE_HI),
      .DIR_SETUP (DIR_SETUP)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .load   (load[gi]),
      .period (period[gi*PW +: PW]),
      .steps  (steps[gi*CNT_W +: CNT_W]),
      .dir_in (dir_in[gi]),
      .enable (enable[gi]),
      .abort  (abort[gi]),
      .step   (step[gi]),
      .dir    (dir[gi]),
      .busy   (busy[gi]),
      .done   (done[gi])
    );
  end

endmodule

// File: tb/tb_sm_step_gen_mc.sv
// Bench for sm_step_gen_mc: timeline model of each channel (elapsed enabled
// cycles, scheduled rising edges) plus literal pulse schedules for key moves.
module tb_sm_step_gen_mc;

  localparam int NCH       = 2;
  localparam int PW        = 17;
  localparam int CNT_W     = 24;
  localparam int PULSE_HI  = 4;
  localparam int DIR_SETUP = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       load, dir_in, enable, abort;
  logic [NCH*PW-1:0]    period;
  logic [NCH*CNT_W-1:0] steps;
  logic [NCH-1:0]       step, dir, busy, done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: a move is a timeline of enabled cycles; rises at DIR_SETUP, then +period each.
  bit m_active [NCH];
  bit m_dir    [NCH];
  bit m_done   [NCH];
  int m_e      [NCH];
  int m_next   [NCH];
  int m_last   [NCH];
  int m_started[NCH];
  int m_total  [NCH];
  int m_pend   [NCH];

  always #5 clk = ~clk;

  sm_step_gen_mc #(
    .NCH(NCH), .PW(PW), .CNT_W(CNT_W), .PULSE_HI(PULSE_HI), .DIR_SETUP(DIR_SETUP)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .period(period), .steps(steps),
    .dir_in(dir_in), .enable(enable), .abort(abort),
    .step(step), .dir(dir), .busy(busy), .done(done)
  );

  function automatic int clampPe(int p);
    return (p < PULSE_HI + 1) ? PULSE_HI + 1 : p;
  endfunction

  function automatic bit inRise(int r, int c);
    return (r >= 0) && (c >= r) && (c < r + PULSE_HI);
  endfunction

  task automatic modelStep();
    for (int ch = 0; ch < NCH; ch++) begin
      if (rst) begin
        m_active[ch] = 0; m_dir[ch] = 0; m_done[ch] = 0;
        m_e[ch] = 0; m_next[ch] = 0; m_last[ch] = 0;
        m_started[ch] = 0; m_total[ch] = 0; m_pend[ch] = 0;
      end else if (m_active[ch]) begin
        m_done[ch] = 0;
        if (abort[ch]) begin
          m_active[ch] = 0;
        end else begin
          if (load[ch]) m_pend[ch] = clampPe(int'(period[ch*PW +: PW]));
          if (enable[ch]) begin
            m_e[ch]++;
            if (m_e[ch] == m_next[ch]) begin
              if (m_started[ch] == m_total[ch]) begin
                m_active[ch] = 0;
                m_done[ch]   = 1;
              end else begin
                m_started[ch]++;
                m_last[ch] = m_e[ch];
                m_next[ch] = m_e[ch] + m_pend[ch];
              end
            end
          end
        end
      end else begin
        m_done[ch] = 0;
        if (load[ch] && !abort[ch]) begin
          if (steps[ch*CNT_W +: CNT_W] != '0) begin
            m_active[ch]  = 1;
            m_e[ch]       = 0;
            m_next[ch]    = DIR_SETUP;
            m_started[ch] = 0;
            m_total[ch]   = int'(steps[ch*CNT_W +: CNT_W]);
            m_pend[ch]    = clampPe(int'(period[ch*PW +: PW]));
            m_dir[ch]     = dir_in[ch];
          end else begin
            m_done[ch] = 1;
          end
        end
      end
    end
  endtask

  task automatic compareVec(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic checkOutput();
    logic [NCH-1:0] e_step, e_dir, e_busy, e_done;
    for (int ch = 0; ch < NCH; ch++) begin
      e_step[ch] = m_active[ch] && (m_started[ch] > 0) && (m_e[ch] - m_last[ch] < PULSE_HI);
      e_dir[ch]  = m_dir[ch];
      e_busy[ch] = m_active[ch];
      e_done[ch] = m_done[ch];
    end
    compareVec("model_step", step, e_step);
    compareVec("model_dir",  dir,  e_dir);
    compareVec("model_busy", busy, e_busy);
    compareVec("model_done", done, e_done);
  endtask

  task automatic applyStimulus();
    modelStep();
    @(negedge clk);
    cyc++;
    checkOutput();
    load  = '0;
    abort = '0;
  endtask

  task automatic checkLit(input string name, input int ch, input logic [3:0] exp);
    logic [3:0] got;
    got = {step[ch], busy[ch], done[ch], dir[ch]};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d ch%0d: step/busy/done/dir got %b expected %b",
               name, cyc, ch, got, exp);
    end
  endtask

  // Cycle 0 carries the command; literal schedule is given relative to it.
  task automatic runPlan(input string name, input int ch, input int per, input int stp, input bit dv,
                         input int pause_from, input int pause_to, input int reload_at, input int reload_per,
                         input int abort_at, input int r0, input int r1, input int r2, input int r3,
                         input int done_at, input int busy_end, input int ncyc);
    int c;
    logic es, eb, ed, edir;
    for (int k = 0; k < ncyc; k++) begin
      if (k == 0) begin
        load[ch] = 1'b1;
        period[ch*PW +: PW] = PW'(per);
        steps[ch*CNT_W +: CNT_W] = CNT_W'(stp);
        dir_in[ch] = dv;
      end
      enable[ch] = !(k >= pause_from && k <= pause_to);
      if (k == reload_at) begin
        load[ch] = 1'b1;
        period[ch*PW +: PW] = PW'(reload_per);
      end
      if (k == abort_at) abort[ch] = 1'b1;
      applyStimulus();
      c    = k + 1;
      es   = (c < busy_end) && (inRise(r0, c) || inRise(r1, c) || inRise(r2, c) || inRise(r3, c));
      eb   = (c >= 1) && (c < busy_end);
      ed   = (c == done_at);
      edir = (busy_end > 1) ? dv : dir[ch];
      checkLit(name, ch, {es, eb, ed, edir});
    end
    enable[ch] = 1'b1;
  endtask

  initial begin
    rst    = 1'b1;
    load   = '0;
    abort  = '0;
    enable = '1;
    dir_in = '0;
    period = '0;
    steps  = '0;
    for (int i = 0; i < NCH; i++) m_active[i] = 0;
    repeat (3) applyStimulus();
    for (int ch = 0; ch < NCH; ch++) checkLit("reset", ch, 4'b0000);
    rst = 1'b0;
    applyStimulus();

    runPlan("basic",      0, 10, 3, 1, -1, -1, -1, 0, -1,  9, 19, 29, -1, 39, 39, 45);
    runPlan("clamp",      0,  2, 2, 0, -1, -1, -1, 0, -1,  9, 14, -1, -1, 19, 19, 25);
    runPlan("zero_steps", 1, 10, 0, 1, -1, -1, -1, 0, -1, -1, -1, -1, -1,  1,  1,  5);
    runPlan("pause",      1, 10, 3, 1, 15, 19, -1, 0, -1,  9, 24, 34, -1, 44, 44, 50);
    runPlan("abort",      0, 10, 100, 0, -1, -1, -1, 0, 20, 9, 19, -1, -1, -1, 21, 30);
    runPlan("abort_load", 0, 10, 5, 1, -1, -1, -1, 0,  0, -1, -1, -1, -1, -1,  1,  5);
    runPlan("reload",     1, 10, 4, 0, -1, -1, 15, 20, -1, 9, 19, 39, 59, 79, 79, 85);

    // Both channels together, then a global reset in the middle of both moves.
    load = '1;
    period[0 +: PW] = PW'(7);  steps[0 +: CNT_W] = CNT_W'(5);
    period[PW +: PW] = PW'(12); steps[CNT_W +: CNT_W] = CNT_W'(3);
    dir_in = 2'b10;
    for (int k = 0; k < 20; k++) begin
      applyStimulus();
      checkLit("dual_ch0", 0, {inRise(9, k + 1) || inRise(16, k + 1), 1'b1, 1'b0, 1'b0});
    end
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    for (int ch = 0; ch < NCH; ch++) checkLit("mid_reset", ch, 4'b0000);

    for (int k = 0; k < 3000; k++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 99) < 8) begin
          load[ch] = 1'b1;
          period[ch*PW +: PW] = PW'($urandom_range(0, 24));
          steps[ch*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 5));
          dir_in[ch] = 1'($urandom_range(0, 1));
        end
        abort[ch]  = ($urandom_range(0, 99) < 2);
        enable[ch] = ($urandom_range(0, 99) < 90);
      end
      rst = ($urandom_range(0, 999) == 0);
      applyStimulus();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
